image_frame_stats: RTL and testbench
====================================

# image_frame_stats

Frame-statistics accelerator sitting directly downstream of the image sensor interface and its 64-entry × 9-bit register file. On a start request it triggers a frame capture through the interface, then waits for the interface done pulse. It then reads all 64 pixels back from the register file and produces per-frame sum, mean, minimum, maximum and above-threshold count, finishing with a one-cycle done pulse.

## Interface
- TIMEOUT, 255 — max cycles spent in WAIT_IF before aborting (1..65535)
- in_clk  input  1  global clock; all logic on rising edge
- in_rst  input  1  reset, synchronous, active-high
- in_start  input  1  start request pulse from host/top
- in_threshold  input  9  count threshold; sampled when in_start is accepted
- out_interface_start  output  1  to image sensor interface; high exactly one cycle per frame
- in_interface_done  input  1  done pulse from image sensor interface
- out_rd_en  output  1  register-file read enable
- out_rd_addr  output  6  register-file read address
- in_rd_data  input  9  register-file read data, valid one cycle after out_rd_addr/out_rd_en
- out_busy  output  1  high in every state except IDLE
- out_done  output  1  one-cycle pulse; results valid and updated this cycle
- out_error  output  1  one-cycle pulse on WAIT_IF timeout
- out_sum  output  15  sum of 64 pixels
- out_mean  output  9  out_sum >> 6
- out_min  output  9  smallest pixel
- out_max  output  9  largest pixel
- out_count  output  7  number of pixels >= sampled threshold (0..64)

## Operation
- FSM states: IDLE, CAPTURE, WAIT_IF, READ, DRAIN, DONE.
- IDLE: in_start=1 → latch in_threshold, go to CAPTURE. Otherwise stay.
- CAPTURE: out_interface_start=1 for this one cycle; clear wait counter → WAIT_IF.
- WAIT_IF: in_interface_done=1 → READ, with addr counter=0 and working accumulators initialised (sum=0, min=511, max=0, count=0).
  - Otherwise increment wait counter. Counter reaching TIMEOUT → out_error pulse, return to IDLE; published results unchanged.
- READ: out_rd_en=1, out_rd_addr=addr counter, incrementing 0..63, one address per cycle.
  - Each cycle after the first, accumulate the in_rd_data returned for the previous address.
  - After address 63 is issued → DRAIN.
- DRAIN: out_rd_en=0; accumulate pixel 63 → DONE.
- DONE: copy working accumulators to the published output registers, out_done=1, → IDLE.
- Accumulate step:
  - sum += pixel (15-bit, never overflows: 64×511=32704).
  - min = pixel<min ? pixel : min; max = pixel>max ? pixel : max.
  - count += (pixel >= threshold), unsigned compare.
- Published outputs change only in DONE. They hold until the next successful frame, so results remain stable across an aborted frame.
- in_start while out_busy=1: ignored, no queuing.
- in_interface_done outside WAIT_IF: ignored.
- in_threshold changes after acceptance: no effect on the current frame.

## Timing
- Reset values: all outputs 0, FSM=IDLE, threshold register 0, working min=511.
- in_rst asserted in any state (including mid-READ) → next edge returns to IDLE. All outputs return to reset values. No done or error pulse is generated.
- Edge N (in_start sampled in IDLE) → CAPTURE; out_interface_start high during cycle N+1.
- WAIT_IF entered at N+2. Done sampled at edge M → first READ cycle M+1 with out_rd_addr=0.
- Address k is issued in READ cycle M+1+k; data is consumed in cycle M+2+k. The last address is issued in cycle M+64.
- DRAIN occurs in cycle M+65; DONE (out_done=1, new results visible) in cycle M+66.
- Latency from the done pulse to out_done is 66 cycles. out_busy is high from N+1 through M+66 inclusive.
- Timeout: done is absent for TIMEOUT consecutive WAIT_IF cycles → out_error high in the following cycle.
- Back-to-back: in_start in the cycle out_done is high is ignored (FSM is still in DONE). in_start the next cycle is accepted.

## Test plan
- All 64 pixels = 256, threshold = 256 → sum=16384, mean=256, min=256, max=256, count=64, out_done one cycle at 66 cycles after interface done.
- Ramp pixel[i] = 8·i, threshold = 256 → sum=16128, mean=252, min=0, max=504, count=32. Check out_rd_addr sequence 0..63 with one address per cycle.
- All pixels = 511, threshold = 0 → sum=32704, mean=511, min=max=511, count=64. Checks no overflow.
- TIMEOUT=10, in_interface_done never asserted → out_error pulses 10 cycles after WAIT_IF entry, out_done never asserts, previous results held, out_busy returns to 0.
- in_start re-pulsed during READ, and in_interface_done pulsed during READ → no effect; single out_interface_start and single out_done per frame.
- in_rst pulsed at READ address 30, then new start with all pixels = 1 → outputs zero after reset, then sum=64, mean=1, min=max=1, count=64 with threshold=1.

Source files
------------

// File: rtl/image_frame_stats.sv
// image_frame_stats: captures a frame through the sensor interface, then
// reads 64 pixels back and publishes sum, mean, min, max and threshold count.
module image_frame_stats #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_start,
   input  logic [8:0]  in_threshold,
   output logic        out_interface_start,
   input  logic        in_interface_done,
   output logic        out_rd_en,
   output logic [5:0]  out_rd_addr,
   input  logic [8:0]  in_rd_data,
   output logic        out_busy,
   output logic        out_done,
   output logic        out_error,
   output logic [14:0] out_sum,
   output logic [8:0]  out_mean,
   output logic [8:0]  out_min,
   output logic [8:0]  out_max,
   output logic [6:0]  out_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_WAIT_IF,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nx;
   logic [15:0] wait_cnt;
   logic [5:0]  addr;
   logic [8:0]  thr;
   logic        rd_vld;
   logic        timeout_hit;

   logic [14:0] acc_sum;
   logic [8:0]  acc_min;
   logic [8:0]  acc_max;
   logic [6:0]  acc_cnt;

   logic [14:0] sum_nx;
   logic [8:0]  min_nx;
   logic [8:0]  max_nx;
   logic [6:0]  cnt_nx;

   assign timeout_hit         = (wait_cnt == TO_LAST);
   assign out_interface_start = (state == S_CAPTURE);
   assign out_rd_en           = (state == S_READ);
   assign out_rd_addr         = addr;
   assign out_busy            = (state != S_IDLE);
   assign out_done            = (state == S_DONE);

   // state register
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic; interface done wins over a timeout in the same cycle
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (in_start) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_nx = S_WAIT_IF;
         end
         S_WAIT_IF: begin
            if (in_interface_done) state_nx = S_READ;
            else if (timeout_hit)  state_nx = S_IDLE;
         end
         S_READ: begin
            if (addr == 6'd63) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // fold the pixel returned by the register file into the running stats
   always_comb begin
      sum_nx = acc_sum + {6'd0, in_rd_data};
      min_nx = (in_rd_data < acc_min) ? in_rd_data : acc_min;
      max_nx = (in_rd_data > acc_max) ? in_rd_data : acc_max;
      cnt_nx = acc_cnt + {6'd0, (in_rd_data >= thr)};
   end

   // datapath: counters, accumulators and published results
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         wait_cnt  <= '0;
         addr      <= '0;
         thr       <= '0;
         rd_vld    <= 1'b0;
         acc_sum   <= '0;
         acc_min   <= 9'd511;
         acc_max   <= '0;
         acc_cnt   <= '0;
         out_error <= 1'b0;
         out_sum   <= '0;
         out_mean  <= '0;
         out_min   <= '0;
         out_max   <= '0;
         out_count <= '0;
      end else begin
         out_error <= 1'b0;
         rd_vld    <= (state == S_READ);
         unique case (state)
            S_IDLE: begin
               if (in_start) thr <= in_threshold;
            end
            S_CAPTURE: begin
               wait_cnt <= '0;
            end
            S_WAIT_IF: begin
               if (in_interface_done) begin
                  addr    <= '0;
                  acc_sum <= '0;
                  acc_min <= 9'd511;
                  acc_max <= '0;
                  acc_cnt <= '0;
               end else if (timeout_hit) begin
                  out_error <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_READ: begin
               addr <= addr + 6'd1;
               if (rd_vld) begin
                  acc_sum <= sum_nx;
                  acc_min <= min_nx;
                  acc_max <= max_nx;
                  acc_cnt <= cnt_nx;
               end
            end
            S_DRAIN: begin
               // publish with the last pixel folded in so the results
               // are already visible in the cycle out_done is high
               acc_sum   <= sum_nx;
               acc_min   <= min_nx;
               acc_max   <= max_nx;
               acc_cnt   <= cnt_nx;
               out_sum   <= sum_nx;
               out_mean  <= sum_nx[14:6];
               out_min   <= min_nx;
               out_max   <= max_nx;
               out_count <= cnt_nx;
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_frame_stats.sv
// tb_image_frame_stats: random and directed frames checked every cycle
// against a frame-level reference model of the statistics block.
module tb_image_frame_stats;

   localparam int TO = 10;

   logic        in_clk = 1'b0;
   logic        in_rst;
   logic        in_start;
   logic [8:0]  in_threshold;
   logic        out_interface_start;
   logic        in_interface_done;
   logic        out_rd_en;
   logic [5:0]  out_rd_addr;
   logic [8:0]  in_rd_data;
   logic        out_busy;
   logic        out_done;
   logic        out_error;
   logic [14:0] out_sum;
   logic [8:0]  out_mean;
   logic [8:0]  out_min;
   logic [8:0]  out_max;
   logic [6:0]  out_count;

   always #5 in_clk = ~in_clk;

   image_frame_stats #(.TIMEOUT(TO)) dut (
      .in_clk              (in_clk),
      .in_rst              (in_rst),
      .in_start            (in_start),
      .in_threshold        (in_threshold),
      .out_interface_start (out_interface_start),
      .in_interface_done   (in_interface_done),
      .out_rd_en           (out_rd_en),
      .out_rd_addr         (out_rd_addr),
      .in_rd_data          (in_rd_data),
      .out_busy            (out_busy),
      .out_done            (out_done),
      .out_error           (out_error),
      .out_sum             (out_sum),
      .out_mean            (out_mean),
      .out_min             (out_min),
      .out_max             (out_max),
      .out_count           (out_count)
   );

   // register file: one-cycle read latency, garbage when not read
   logic [8:0] mem [64];
   always @(posedge in_clk) begin
      if (out_rd_en) in_rd_data <= mem[out_rd_addr];
      else           in_rd_data <= 9'($urandom);
   end

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic        exp_istart, exp_rd_en, exp_busy, exp_done, exp_error;
   logic [5:0]  exp_addr;
   int          exp_sum, exp_mean, exp_min, exp_max, exp_count;
   int          m_sum, m_min, m_max, m_cnt;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // frame statistics straight from the pixel array
   task automatic model(input logic [8:0] thr);
      m_sum = 0; m_min = 511; m_max = 0; m_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         m_sum += int'(mem[i]);
         if (int'(mem[i]) < m_min) m_min = int'(mem[i]);
         if (int'(mem[i]) > m_max) m_max = int'(mem[i]);
         if (mem[i] >= thr) m_cnt++;
      end
   endtask

   // compare process
   always @(negedge in_clk) begin
      if (chk_en) begin
         chk("interface_start", out_interface_start, exp_istart);
         chk("rd_en", out_rd_en, exp_rd_en);
         if (exp_rd_en) chk("rd_addr", out_rd_addr, exp_addr);
         chk("busy", out_busy, exp_busy);
         chk("done", out_done, exp_done);
         chk("error", out_error, exp_error);
         chk("sum", out_sum, exp_sum);
         chk("mean", out_mean, exp_mean);
         chk("min", out_min, exp_min);
         chk("max", out_max, exp_max);
         chk("count", out_count, exp_count);
      end
   end

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic clear_results();
      exp_sum = 0; exp_mean = 0; exp_min = 0; exp_max = 0; exp_count = 0;
   endtask

   task automatic run_frame(input logic [8:0] thr, input int wait_n,
                            input bit timeout, input bit noise,
                            input int rst_addr, input bit b2b);
      in_start = 1'b1;
      in_threshold = thr;
      model(thr);
      step();
      in_start = 1'b0;
      exp_istart = 1'b1;
      exp_busy = 1'b1;
      if (noise) in_threshold = 9'($urandom);
      step();
      exp_istart = 1'b0;
      if (timeout) begin
         repeat (TO) step();
         exp_error = 1'b1;
         exp_busy = 1'b0;
         step();
         exp_error = 1'b0;
         return;
      end
      for (int i = 0; i <= wait_n; i++) begin
         in_interface_done = (i == wait_n);
         if (noise && i < wait_n) in_start = 1'($urandom);
         step();
      end
      in_interface_done = 1'b0;
      in_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         exp_rd_en = 1'b1;
         exp_addr = 6'(k);
         if (noise) begin
            in_start = 1'($urandom);
            in_interface_done = 1'($urandom);
         end
         if (k == rst_addr) begin
            in_rst = 1'b1;
            step();
            in_rst = 1'b0;
            exp_rd_en = 1'b0;
            exp_busy = 1'b0;
            clear_results();
            step();
            return;
         end
         step();
      end
      in_start = 1'b0;
      in_interface_done = 1'b0;
      exp_rd_en = 1'b0;
      step();
      exp_done = 1'b1;
      exp_sum = m_sum;
      exp_mean = m_sum / 64;
      exp_min = m_min;
      exp_max = m_max;
      exp_count = m_cnt;
      if (b2b) in_start = 1'b1;
      step();
      in_start = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
   endtask

   initial begin
      in_rst = 1'b1;
      in_start = 1'b0;
      in_threshold = '0;
      in_interface_done = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      exp_istart = 0; exp_rd_en = 0; exp_busy = 0;
      exp_done = 0; exp_error = 0; exp_addr = '0;
      clear_results();
      step();
      chk_en = 1'b1;
      step();
      in_rst = 1'b0;
      step();

      for (int i = 0; i < 64; i++) mem[i] = 9'd256;
      model(9'd256);
      chk("pin1_sum", m_sum, 16384);
      chk("pin1_count", m_cnt, 64);
      run_frame(9'd256, 3, 0, 0, -1, 0);

      for (int i = 0; i < 64; i++) mem[i] = 9'(8 * i);
      model(9'd256);
      chk("pin2_sum", m_sum, 16128);
      chk("pin2_mean", m_sum / 64, 252);
      chk("pin2_min", m_min, 0);
      chk("pin2_max", m_max, 504);
      chk("pin2_count", m_cnt, 32);
      run_frame(9'd256, 0, 0, 0, -1, 1);

      for (int i = 0; i < 64; i++) mem[i] = 9'd511;
      model(9'd0);
      chk("pin3_sum", m_sum, 32704);
      chk("pin3_count", m_cnt, 64);
      run_frame(9'd0, TO - 1, 0, 0, -1, 0);

      run_frame(9'd5, 0, 1, 0, -1, 0);
      step();

      for (int i = 0; i < 64; i++) mem[i] = 9'($urandom);
      run_frame(9'($urandom), 4, 0, 1, -1, 0);

      run_frame(9'd100, 2, 0, 0, 30, 0);
      for (int i = 0; i < 64; i++) mem[i] = 9'd1;
      model(9'd1);
      chk("pin6_sum", m_sum, 64);
      chk("pin6_min", m_min, 1);
      chk("pin6_count", m_cnt, 64);
      run_frame(9'd1, 1, 0, 0, -1, 0);

      for (int f = 0; f < 24; f++) begin
         int mode;
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 64; i++) begin
            if (mode == 0)      mem[i] = 9'($urandom_range(0, 3));
            else if (mode == 1) mem[i] = 9'($urandom_range(508, 511));
            else                mem[i] = 9'($urandom);
         end
         run_frame(9'($urandom), $urandom_range(0, TO - 1),
                   ($urandom_range(0, 7) == 0), 1'($urandom), -1,
                   1'($urandom));
         repeat ($urandom_range(0, 2)) step();
      end

      step();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
